wb_port_arbiter: RTL

//  Shares the single register-file write port, and the commit/difftest trace, between the in-order

---
 rtl/wb_port_arbiter_pkg.sv | 34 +++
 rtl/wb_port_arbiter_if.sv | 46 ++++
 rtl/gen_en_dff.sv | 24 ++
 rtl/wb_port_arbiter_pend_buf.sv | 80 ++++++++
 rtl/wb_port_arbiter.sv | 117 +++++++++++
 5 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, grant encodings and the writeback entry layout for the writeback port arbiter.
package wb_port_arbiter_pkg;

  localparam int ADDR_W = 64;
  localparam int INST_W = 32;
  localparam int REG_W  = 64;
  localparam int RD_W   = 5;

  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_PIPE = 2'd1,
    WB_SRC_MDU  = 2'd2,
    WB_SRC_PEND = 2'd3
  } wb_src_e;

  typedef enum logic [1:0] {
    PB_EMPTY = 2'd0,
    PB_HELD  = 2'd1,
    PB_FORCE = 2'd2
  } pb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic [RD_W-1:0]   rd;
    logic [REG_W-1:0]  data;
  } wb_ent_t;

  // x0 is hardwired to zero, so a write to it is retired but never reaches the regfile.
  function automatic logic rd_writes(input logic wen, input logic [RD_W-1:0] rd);
    return wen & (rd != '0);
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback-side bus: pipeline and MDU results in, regfile write / commit trace / hazard info out.
interface wb_port_arbiter_if;
  import wb_port_arbiter_pkg::*;

  logic              pipe_valid;
  logic              pipe_ready;
  logic [ADDR_W-1:0] pipe_pc;
  logic [INST_W-1:0] pipe_inst;
  logic              pipe_rd_wen;
  logic [RD_W-1:0]   pipe_rd_addr;
  logic [REG_W-1:0]  pipe_rd_data;

  logic              mdu_valid;
  logic              mdu_ready;
  logic [ADDR_W-1:0] mdu_pc;
  logic [INST_W-1:0] mdu_inst;
  logic [RD_W-1:0]   mdu_rd_addr;
  logic [REG_W-1:0]  mdu_rd_data;

  logic              rf_wen;
  logic [RD_W-1:0]   rf_waddr;
  logic [REG_W-1:0]  rf_wdata;
  logic              commit_valid;
  logic [ADDR_W-1:0] commit_pc;
  logic [INST_W-1:0] commit_inst;
  logic              pend_valid;
  logic [RD_W-1:0]   pend_rd;
  logic              stall_req;

  modport master (
    output pipe_valid, pipe_pc, pipe_inst, pipe_rd_wen, pipe_rd_addr, pipe_rd_data,
    output mdu_valid, mdu_pc, mdu_inst, mdu_rd_addr, mdu_rd_data,
    input  pipe_ready, mdu_ready,
    input  rf_wen, rf_waddr, rf_wdata, commit_valid, commit_pc, commit_inst,
    input  pend_valid, pend_rd, stall_req
  );

  modport slave (
    input  pipe_valid, pipe_pc, pipe_inst, pipe_rd_wen, pipe_rd_addr, pipe_rd_data,
    input  mdu_valid, mdu_pc, mdu_inst, mdu_rd_addr, mdu_rd_data,
    output pipe_ready, mdu_ready,
    output rf_wen, rf_waddr, rf_wdata, commit_valid, commit_pc, commit_inst,
    output pend_valid, pend_rd, stall_req
  );

endinterface

// File: rtl/gen_en_dff.sv
// Enable flop with synchronous active-high clear; holds its value when i_en is low.
module gen_en_dff #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/wb_port_arbiter_pend_buf.sv
// One-entry park buffer for an MDU result that lost the port, with a starvation counter.
// Write and drain are never in the same cycle; FORCE raises stall_req for exactly one drain cycle.
module wb_pend_buf
  import wb_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_wr,
  input  wb_ent_t i_wr_ent,
  input  logic    i_drain,
  output logic    o_pend_valid,
  output wb_ent_t o_pend_ent,
  output logic    o_stall_req
);

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(STARVE_LIMIT - 1);

  pb_state_e        r_state;
  pb_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  wb_ent_t          r_ent;
  logic             w_load;

  assign w_load = i_wr & (r_state == PB_EMPTY);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= PB_EMPTY;
      r_cnt   <= '0;
      r_ent   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) begin
        r_ent <= i_wr_ent;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      PB_EMPTY: begin
        if (w_load) begin
          w_state_nxt = PB_HELD;
          w_cnt_nxt   = '0;
        end
      end
      PB_HELD: begin
        if (i_drain) begin
          w_state_nxt = PB_EMPTY;
        end else begin
          if (r_cnt >= LAST_WAIT) begin
            w_state_nxt = PB_FORCE;
          end
          // Saturate rather than wrap so a long wait can never look short.
          if (r_cnt != '1) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      PB_FORCE: begin
        w_state_nxt = PB_EMPTY;
      end
      default: begin
        w_state_nxt = PB_EMPTY;
      end
    endcase
  end

  assign o_pend_valid = (r_state != PB_EMPTY);
  assign o_stall_req  = (r_state == PB_FORCE);
  assign o_pend_ent   = r_ent;

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the regfile write port and commit trace between pipeline writeback and MDU results.
// Latency 1 to rf_*/commit_*; pipeline wins, MDU loser parks, starvation raises a one-cycle stall.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  wb_port_arbiter_if.slave  io_bus
);

  logic    w_pend_valid;
  logic    w_stall_req;
  wb_ent_t w_pend_ent;
  wb_ent_t w_pipe_ent;
  wb_ent_t w_mdu_ent;
  wb_ent_t w_sel_ent;
  wb_src_e w_src;
  logic    w_sel_wen;
  logic    w_grant;
  logic    w_g_pend;
  logic    w_g_pipe;
  logic    w_g_mdu;
  logic    w_buf_wr;

  assign w_pipe_ent = '{pc:   io_bus.pipe_pc,
                        inst: io_bus.pipe_inst,
                        rd:   io_bus.pipe_rd_addr,
                        data: io_bus.pipe_rd_data};
  assign w_mdu_ent  = '{pc:   io_bus.mdu_pc,
                        inst: io_bus.mdu_inst,
                        rd:   io_bus.mdu_rd_addr,
                        data: io_bus.mdu_rd_data};

  assign w_g_pend = w_pend_valid & (w_stall_req | ~io_bus.pipe_valid);
  assign w_g_pipe = io_bus.pipe_valid & ~w_stall_req;
  assign w_g_mdu  = ~w_pend_valid & io_bus.mdu_valid & ~io_bus.pipe_valid;
  // mdu_ready is ~pend_valid, so an accepted MDU result that loses to the pipe parks.
  assign w_buf_wr = io_bus.mdu_valid & ~w_pend_valid & io_bus.pipe_valid & ~w_stall_req;

  always_comb begin
    w_src     = WB_SRC_NONE;
    w_sel_ent = '0;
    w_sel_wen = 1'b0;
    if (w_g_pend) begin
      w_src     = WB_SRC_PEND;
      w_sel_ent = w_pend_ent;
      w_sel_wen = rd_writes(1'b1, w_pend_ent.rd);
    end else if (w_g_pipe) begin
      w_src     = WB_SRC_PIPE;
      w_sel_ent = w_pipe_ent;
      w_sel_wen = rd_writes(io_bus.pipe_rd_wen, io_bus.pipe_rd_addr);
    end else if (w_g_mdu) begin
      w_src     = WB_SRC_MDU;
      w_sel_ent = w_mdu_ent;
      w_sel_wen = rd_writes(1'b1, io_bus.mdu_rd_addr);
    end
  end

  assign w_grant = (w_src != WB_SRC_NONE);

  wb_pend_buf #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_pend_buf (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_wr         (w_buf_wr),
    .i_wr_ent     (w_mdu_ent),
    .i_drain      (w_g_pend),
    .o_pend_valid (w_pend_valid),
    .o_pend_ent   (w_pend_ent),
    .o_stall_req  (w_stall_req)
  );

  logic              r_commit_valid;
  logic              r_rf_wen;
  logic [RD_W-1:0]   r_rf_waddr;
  logic [REG_W-1:0]  r_rf_wdata;
  logic [ADDR_W-1:0] r_commit_pc;
  logic [INST_W-1:0] r_commit_inst;

  // Strobes reload every cycle; payload registers only move on a grant and hold otherwise.
  gen_en_dff #(.W(1)) u_commit_valid (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(1'b1), .i_d(w_grant), .o_q(r_commit_valid)
  );
  gen_en_dff #(.W(1)) u_rf_wen (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(1'b1), .i_d(w_sel_wen), .o_q(r_rf_wen)
  );
  gen_en_dff #(.W(RD_W)) u_rf_waddr (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(w_grant), .i_d(w_sel_ent.rd), .o_q(r_rf_waddr)
  );
  gen_en_dff #(.W(REG_W)) u_rf_wdata (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(w_grant), .i_d(w_sel_ent.data), .o_q(r_rf_wdata)
  );
  gen_en_dff #(.W(ADDR_W)) u_commit_pc (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(w_grant), .i_d(w_sel_ent.pc), .o_q(r_commit_pc)
  );
  gen_en_dff #(.W(INST_W)) u_commit_inst (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(w_grant), .i_d(w_sel_ent.inst), .o_q(r_commit_inst)
  );

  assign io_bus.pipe_ready   = ~w_stall_req;
  assign io_bus.mdu_ready    = ~w_pend_valid;
  assign io_bus.rf_wen       = r_rf_wen;
  assign io_bus.rf_waddr     = r_rf_waddr;
  assign io_bus.rf_wdata     = r_rf_wdata;
  assign io_bus.commit_valid = r_commit_valid;
  assign io_bus.commit_pc    = r_commit_pc;
  assign io_bus.commit_inst  = r_commit_inst;
  assign io_bus.pend_valid   = w_pend_valid;
  assign io_bus.pend_rd      = w_pend_ent.rd;
  assign io_bus.stall_req    = w_stall_req;

endmodule
